// File: rtl/step_dir_monitor.sv
`default_nettype none
// ============================================================================
// Module   : step_dir_monitor
// Brief    : Synchronizes a step/dir pair, counts accepted steps and flags
//            setup, pulse-width, hold and step-count-wrap violations.
// Revision : 1.0 - initial release
// ============================================================================
module step_dir_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic        dir,
    input  logic [31:0] min_setup,
    input  logic [31:0] min_pulse,
    input  logic [31:0] min_hold,
    input  logic        clear,
    output logic [31:0] position,
    output logic [31:0] step_count,
    output logic [3:0]  err,
    output logic        step_stb,
    output logic        step_dir
);

    localparam int               ARM_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES);
    localparam logic [31:0]      ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] step_sync, dir_sync;
    logic                   step_p, dir_p;
    logic [31:0]            dir_age, high_cnt, hold_cnt;
    logic [31:0]            high_next, hold_next;
    logic [ARM_W-1:0]       arm_cnt, arm_next;

    logic        step_s, dir_s, rise, fall, dir_chg;
    logic        accept, setup_err, pulse_err, hold_err, wrap_err;
    logic [31:0] pos_base, cnt_base, pos_next, cnt_next;
    logic [3:0]  err_next;

    assign step_s  = step_sync[SYNC_STAGES-1];
    assign dir_s   = dir_sync[SYNC_STAGES-1];
    assign rise    = step_s & ~step_p;
    assign fall    = ~step_s & step_p;
    assign dir_chg = dir_s ^ dir_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_sync <= '0;
            dir_sync  <= '0;
            step_p    <= 1'b0;
            dir_p     <= 1'b0;
            dir_age   <= '0;
        end else begin
            step_sync <= {step_sync[SYNC_STAGES-2:0], step};
            dir_sync  <= {dir_sync[SYNC_STAGES-2:0], dir};
            step_p    <= step_s;
            dir_p     <= dir_s;
            if (dir_chg)
                dir_age <= '0;
            else if (dir_age != ALL_ONES)
                dir_age <= dir_age + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_ARM;
            high_cnt <= '0;
            hold_cnt <= '0;
            arm_cnt  <= '0;
        end else begin
            state    <= state_next;
            high_cnt <= high_next;
            hold_cnt <= hold_next;
            arm_cnt  <= arm_next;
        end
    end

    // ARM waits until the synchronizer has refilled after reset, so a step
    // held high through reset never looks like a fresh rise.
    always_comb begin
        state_next = state;
        high_next  = high_cnt;
        hold_next  = hold_cnt;
        arm_next   = arm_cnt;
        accept     = 1'b0;
        pulse_err  = 1'b0;
        hold_err   = 1'b0;
        case (state)
            ST_ARM: begin
                if (arm_cnt != ARM_DONE)
                    arm_next = arm_cnt + 1'b1;
                else if (!step_s)
                    state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise) begin
                    accept     = 1'b1;
                    high_next  = 32'd1;
                    state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    pulse_err  = (high_cnt < min_pulse);
                    hold_next  = '0;
                    state_next = ST_HOLD;
                end else if (step_s && high_cnt != ALL_ONES) begin
                    high_next = high_cnt + 32'd1;
                end
            end
            ST_HOLD: begin
                hold_err = dir_chg && (hold_cnt < min_hold);
                if (hold_cnt != ALL_ONES)
                    hold_next = hold_cnt + 32'd1;
                if (rise) begin
                    accept     = 1'b1;
                    high_next  = 32'd1;
                    state_next = ST_HIGH;
                end else if (hold_cnt >= min_hold) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_ARM;
        endcase
    end

    // clear zeroes the bases first so a same-cycle step or error still lands.
    always_comb begin
        pos_base  = clear ? 32'd0 : position;
        cnt_base  = clear ? 32'd0 : step_count;
        setup_err = accept && ((dir_age < min_setup) || (dir_chg && (min_setup != 32'd0)));
        wrap_err  = accept && (cnt_base == ALL_ONES);
        pos_next  = pos_base;
        cnt_next  = cnt_base;
        if (accept) begin
            pos_next = dir_s ? (pos_base + 32'd1) : (pos_base - 32'd1);
            cnt_next = cnt_base + 32'd1;
        end
        err_next = (clear ? 4'd0 : err) | {wrap_err, hold_err, pulse_err, setup_err};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            position   <= '0;
            step_count <= '0;
            err        <= '0;
            step_stb   <= 1'b0;
            step_dir   <= 1'b0;
        end else begin
            position   <= pos_next;
            step_count <= cnt_next;
            err        <= err_next;
            step_stb   <= accept;
            if (accept)
                step_dir <= dir_s;
        end
    end

endmodule
`default_nettype wire
